// File: rtl/order_msg_arbiter.sv
// Round-robin arbiter sharing one order-message egress channel between NUM_REQ
// packet sources; disabled or unknown message types are drained and counted.
module order_msg_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 64
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_REQ-1:0]           s_valid,
  output logic [NUM_REQ-1:0]           s_ready,
  input  logic [NUM_REQ*DATA_W-1:0]    s_data,
  input  logic [NUM_REQ-1:0]           s_last,
  input  logic [NUM_REQ*8-1:0]         s_msg_type,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic [DATA_W-1:0]            m_data,
  output logic                         m_last,
  output logic [7:0]                   m_msg_type,
  output logic [$clog2(NUM_REQ)-1:0]   m_src_id,
  input  logic [3:0]                   cfg_type_en,
  input  logic                         cfg_cancel_prio,
  output logic [15:0]                  drop_count
);

  localparam int SRC_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {ST_IDLE, ST_FWD, ST_DROP} state_t;

  state_t             state_q, state_d;
  logic [SRC_W-1:0]   rr_q, rr_d;
  logic [SRC_W-1:0]   src_q, src_d;
  logic [7:0]         type_q, type_d;
  logic [15:0]        drop_q, drop_d;

  logic [NUM_REQ-1:0] cancel_vec;
  logic [NUM_REQ-1:0] cand;
  logic [SRC_W-1:0]   grant;
  logic [7:0]         grant_type;
  logic               sel_valid;
  logic               sel_last;
  logic [DATA_W-1:0]  sel_data;

  function automatic logic type_fwd(input logic [7:0] t, input logic [3:0] en);
    case (t)
      8'h4F:   return en[0];
      8'h55:   return en[1];
      8'h58:   return en[2];
      8'h4D:   return en[3];
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [SRC_W-1:0] next_idx(input logic [SRC_W-1:0] i);
    if (int'(i) == NUM_REQ - 1) return '0;
    return i + 1'b1;
  endfunction

  // First set bit of c at or above ptr, wrapping modulo NUM_REQ.
  function automatic logic [SRC_W-1:0] rr_pick(input logic [NUM_REQ-1:0] c,
                                               input logic [SRC_W-1:0] ptr);
    logic [SRC_W-1:0] idx;
    logic [SRC_W-1:0] pick;
    logic             found;
    idx   = ptr;
    pick  = ptr;
    found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && c[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
      idx = next_idx(idx);
    end
    return pick;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_comb begin
    cancel_vec = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cancel_vec[i] = s_valid[i] && (s_msg_type[i*8 +: 8] == 8'h58);
    end
    cand = (cfg_cancel_prio && (|cancel_vec)) ? cancel_vec : s_valid;
  end

  assign grant      = rr_pick(cand, rr_q);
  assign grant_type = s_msg_type[int'(grant)*8 +: 8];
  assign sel_valid  = s_valid[src_q];
  assign sel_last   = s_last[src_q];
  assign sel_data   = s_data[int'(src_q)*DATA_W +: DATA_W];

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    src_d   = src_q;
    type_d  = type_q;
    drop_d  = drop_q;
    s_ready = '0;
    m_valid = 1'b0;
    m_data  = '0;
    m_last  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (|s_valid) begin
          src_d   = grant;
          type_d  = grant_type;
          state_d = type_fwd(grant_type, cfg_type_en) ? ST_FWD : ST_DROP;
        end
      end
      ST_FWD: begin
        m_valid        = sel_valid;
        m_data         = sel_data;
        m_last         = sel_last;
        s_ready[src_q] = m_ready;
        if (sel_valid && m_ready && sel_last) begin
          state_d = ST_IDLE;
          rr_d    = next_idx(src_q);
        end
      end
      ST_DROP: begin
        s_ready[src_q] = 1'b1;
        if (sel_valid && sel_last) begin
          state_d = ST_IDLE;
          rr_d    = next_idx(src_q);
          drop_d  = sat_inc16(drop_q);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      rr_q    <= '0;
      src_q   <= '0;
      type_q  <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      src_q   <= src_d;
      type_q  <= type_d;
      drop_q  <= drop_d;
    end
  end

  assign m_msg_type = type_q;
  assign m_src_id   = src_q;
  assign drop_count = drop_q;

endmodule

// File: tb/tb_order_msg_arbiter.sv
// Directed bench for order_msg_arbiter: round-robin, cancel priority, drop path,
// backpressure and mid-packet reset, each step checked against hand values.
module tb_order_msg_arbiter;
  localparam int NR = 4;
  localparam int DW = 64;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [NR-1:0]    s_valid;
  logic [NR-1:0]    s_ready;
  logic [NR*DW-1:0] s_data;
  logic [NR-1:0]    s_last;
  logic [NR*8-1:0]  s_msg_type;
  logic             m_valid;
  logic             m_ready;
  logic [DW-1:0]    m_data;
  logic             m_last;
  logic [7:0]       m_msg_type;
  logic [1:0]       m_src_id;
  logic [3:0]       cfg_type_en;
  logic             cfg_cancel_prio;
  logic [15:0]      drop_count;

  always #5 clk = ~clk;

  order_msg_arbiter #(.NUM_REQ(NR), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .s_msg_type(s_msg_type),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .m_msg_type(m_msg_type), .m_src_id(m_src_id),
    .cfg_type_en(cfg_type_en), .cfg_cancel_prio(cfg_cancel_prio),
    .drop_count(drop_count)
  );

  int vectors = 0;
  int miscompares = 0;

  int         len[NR];
  int         beat[NR];
  int         pkts[NR];
  int         sent[NR];
  logic [7:0] typ[NR];

  // Beat payload: requester id, packet number of that requester, beat index.
  function automatic logic [63:0] mkd(input int i, input int n, input int b);
    return {8'(i), 24'(n), 32'(b)};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < NR; i++) begin
      s_valid[i]          = (pkts[i] > 0);
      s_data[i*DW +: DW]  = mkd(i, sent[i], beat[i]);
      s_last[i]           = (beat[i] == len[i] - 1);
      s_msg_type[i*8 +: 8] = typ[i];
    end
  endtask

  // One clock: sources advance on the handshakes seen before the edge.
  task automatic tick();
    logic [NR-1:0] hs;
    hs = s_valid & s_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < NR; i++) begin
      if (hs[i]) begin
        if (beat[i] == len[i] - 1) begin
          beat[i] = 0;
          sent[i]++;
          pkts[i]--;
        end else begin
          beat[i]++;
        end
      end
    end
    drive();
    @(negedge clk);
  endtask

  task automatic reset_pulse();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int   ord[5];
    int   pn[5];
    logic mr[5];
    int   eb[5];
    ord = '{0, 1, 2, 3, 0};
    pn  = '{0, 0, 0, 0, 1};
    mr  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    eb  = '{0, 1, 1, 1, 2};

    rst_n = 1'b0;
    m_ready = 1'b0;
    cfg_type_en = 4'h0;
    cfg_cancel_prio = 1'b0;
    for (int i = 0; i < NR; i++) begin
      len[i] = 1; beat[i] = 0; pkts[i] = 0; sent[i] = 0; typ[i] = 8'h00;
    end
    drive();
    repeat (2) @(negedge clk);

    chk("rst_s_ready", s_ready, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_last", m_last, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_m_msg_type", m_msg_type, 0);
    chk("rst_m_src_id", m_src_id, 0);
    chk("rst_drop_count", drop_count, 0);

    // Round-robin fairness with all requesters busy
    rst_n = 1'b1;
    cfg_type_en = 4'hF;
    m_ready = 1'b1;
    for (int i = 0; i < NR; i++) begin
      len[i] = 2; typ[i] = 8'h4F; pkts[i] = (i == 0) ? 2 : 1;
    end
    drive();
    for (int p = 0; p < 5; p++) begin
      chk("rr_bubble", m_valid, 0);
      tick();
      chk("rr_src", m_src_id, 64'(ord[p]));
      chk("rr_valid", m_valid, 1);
      chk("rr_beat0", m_data, mkd(ord[p], pn[p], 0));
      chk("rr_last0", m_last, 0);
      tick();
      chk("rr_beat1", m_data, mkd(ord[p], pn[p], 1));
      chk("rr_last1", m_last, 1);
      tick();
    end

    // Cancel priority enabled: req2 'X' beats req0 'O' with rr = 0
    reset_pulse();
    cfg_cancel_prio = 1'b1;
    len[0] = 1; typ[0] = 8'h4F; pkts[0] = 1;
    len[2] = 1; typ[2] = 8'h58; pkts[2] = 1;
    drive();
    chk("cp_idle", m_valid, 0);
    tick();
    chk("cp_src_first", m_src_id, 2);
    chk("cp_type_first", m_msg_type, 8'h58);
    chk("cp_valid", m_valid, 1);
    chk("cp_data", m_data, mkd(2, 1, 0));
    chk("cp_last", m_last, 1);
    chk("cp_ready", s_ready, 4'b0100);
    tick();
    chk("cp_bubble", m_valid, 0);
    tick();
    chk("cp_src_second", m_src_id, 0);
    chk("cp_type_second", m_msg_type, 8'h4F);
    chk("cp_data_second", m_data, mkd(0, 2, 0));
    tick();

    // Cancel priority disabled: plain round-robin from rr = 0
    reset_pulse();
    cfg_cancel_prio = 1'b0;
    pkts[0] = 1;
    pkts[2] = 1;
    drive();
    tick();
    chk("np_src_first", m_src_id, 0);
    chk("np_type_first", m_msg_type, 8'h4F);
    chk("np_data_first", m_data, mkd(0, 3, 0));
    tick();
    tick();
    chk("np_src_second", m_src_id, 2);
    chk("np_type_second", m_msg_type, 8'h58);
    chk("np_data_second", m_data, mkd(2, 2, 0));
    tick();

    // Drop path: 'M' disabled, then an unknown type
    cfg_type_en = 4'h7;
    len[1] = 3; typ[1] = 8'h4D; pkts[1] = 1;
    drive();
    chk("dr_idle", m_valid, 0);
    tick();
    for (int b = 0; b < 3; b++) begin
      chk("dr_m_valid", m_valid, 0);
      chk("dr_s_ready", s_ready, 4'b0010);
      tick();
    end
    chk("dr_count1", drop_count, 1);
    chk("dr_type_m", m_msg_type, 8'h4D);
    len[1] = 1; typ[1] = 8'h41; pkts[1] = 1;
    drive();
    tick();
    chk("dr_unk_ready", s_ready, 4'b0010);
    chk("dr_unk_valid", m_valid, 0);
    chk("dr_unk_type", m_msg_type, 8'h41);
    tick();
    chk("dr_count2", drop_count, 2);

    // Backpressure during a 3-beat 'U' packet from req1
    cfg_type_en = 4'hF;
    len[1] = 3; typ[1] = 8'h55; pkts[1] = 1;
    drive();
    tick();
    for (int c = 0; c < 5; c++) begin
      m_ready = mr[c];
      #1;
      chk("bp_valid", m_valid, 1);
      chk("bp_data", m_data, mkd(1, 3, eb[c]));
      chk("bp_last", m_last, (eb[c] == 2) ? 1 : 0);
      chk("bp_ready", s_ready, mr[c] ? 4'b0010 : 4'b0000);
      chk("bp_type", m_msg_type, 8'h55);
      tick();
    end
    m_ready = 1'b1;
    chk("bp_done", m_valid, 0);

    // Mid-packet reset during the second beat of req3
    len[3] = 3; typ[3] = 8'h4F; pkts[3] = 1;
    drive();
    tick();
    tick();
    chk("mr_src_pre", m_src_id, 3);
    chk("mr_data_pre", m_data, mkd(3, 1, 1));
    rst_n = 1'b0;
    #1;
    chk("mr_valid", m_valid, 0);
    chk("mr_s_ready", s_ready, 0);
    chk("mr_data", m_data, 0);
    chk("mr_last", m_last, 0);
    chk("mr_src", m_src_id, 0);
    chk("mr_type", m_msg_type, 0);
    chk("mr_drop", drop_count, 0);
    @(negedge clk);
    rst_n = 1'b1;
    beat[3] = 0;
    len[0] = 1; typ[0] = 8'h4F; pkts[0] = 1;
    drive();
    chk("mr_idle", m_valid, 0);
    tick();
    chk("mr_src_restart", m_src_id, 0);
    chk("mr_data_restart", m_data, mkd(0, 4, 0));
    tick();
    tick();
    chk("mr_src_retry", m_src_id, 3);
    chk("mr_data_retry", m_data, mkd(3, 1, 0));
    tick();
    tick();
    tick();
    chk("mr_end_valid", m_valid, 0);
    chk("mr_end_drop", drop_count, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
